tmr_scrub_ctrl: RTL



---
 rtl/tmr_pkg.sv | 8 +
 rtl/tmr_vote_cmp.sv | 18 +
 rtl/tmr_scrub_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/tmr_pkg.sv
// tmr_pkg: shared types and helpers for the DTMR scrub logic
package tmr_pkg;
  localparam int NUM_REP = 3;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SCRUB, S_VERIFY, S_REPORT, S_FAULT} state_e;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/tmr_vote_cmp.sv
// tmr_vote_cmp: bitwise majority vote of three replicas and per-replica disagreement flags
module tmr_vote_cmp
  import tmr_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0]   rep0,
  input  logic [WIDTH-1:0]   rep1,
  input  logic [WIDTH-1:0]   rep2,
  output logic [WIDTH-1:0]   vote,
  output logic [NUM_REP-1:0] mis
);
  always_comb begin
    vote = '0;
    for (int i = 0; i < WIDTH; i++) vote[i] = maj3(rep0[i], rep1[i], rep2[i]);
    mis = {|(rep2 ^ vote), |(rep1 ^ vote), |(rep0 ^ vote)};
  end
endmodule

// File: rtl/tmr_scrub_ctrl.sv
// tmr_scrub_ctrl: periodic TMR check, voted reload with bounded retries, and host error reporting
module tmr_scrub_ctrl
  import tmr_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int PERIOD    = 16,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   rep0,
  input  logic [WIDTH-1:0]   rep1,
  input  logic [WIDTH-1:0]   rep2,
  input  logic               force_chk,
  output logic               scrub_en,
  output logic [WIDTH-1:0]   scrub_data,
  output logic [NUM_REP-1:0] bad_mask,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               irq_req,
  input  logic               irq_ack,
  output logic               busy,
  output logic               fault
);
  localparam int TW = $clog2(PERIOD);
  localparam int RW = $clog2(MAX_RETRY + 1);
  state_e             state_q;
  logic [TW-1:0]      timer_q;
  logic [RW-1:0]      retry_q;
  logic [WIDTH-1:0]   scrub_data_q;
  logic [NUM_REP-1:0] bad_mask_q;
  logic [CNT_W-1:0]   err_cnt_q;
  logic               irq_req_q;
  logic               fault_q;
  logic [WIDTH-1:0]   vote;
  logic [NUM_REP-1:0] mis;
  tmr_vote_cmp #(.WIDTH(WIDTH)) u_vote (
    .rep0(rep0),
    .rep1(rep1),
    .rep2(rep2),
    .vote(vote),
    .mis (mis)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      retry_q      <= '0;
      scrub_data_q <= '0;
      bad_mask_q   <= '0;
      err_cnt_q    <= '0;
      irq_req_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:
          if (timer_q == TW'(PERIOD - 1) || force_chk) begin
            timer_q <= '0;
            state_q <= S_CHECK;
          end else timer_q <= timer_q + 1'b1;
        S_CHECK:
          if (mis == '0) state_q <= S_IDLE;
          else begin
            bad_mask_q   <= mis;
            scrub_data_q <= vote;
            err_cnt_q    <= &err_cnt_q ? err_cnt_q : err_cnt_q + 1'b1;
            retry_q      <= '0;
            state_q      <= S_SCRUB;
          end
        S_SCRUB: state_q <= S_VERIFY;
        S_VERIFY:
          if (mis == '0) begin
            irq_req_q <= 1'b1;
            state_q   <= S_REPORT;
          end else if (int'(retry_q) + 1 == MAX_RETRY) begin
            irq_req_q <= 1'b1;
            fault_q   <= 1'b1;
            state_q   <= S_FAULT;
          end else begin
            retry_q    <= retry_q + 1'b1;
            bad_mask_q <= mis;
            state_q    <= S_SCRUB;
          end
        S_REPORT:
          if (irq_ack) begin
            irq_req_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        S_FAULT: state_q <= S_FAULT;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign scrub_en   = state_q == S_SCRUB;
  assign busy       = state_q != S_IDLE;
  assign scrub_data = scrub_data_q;
  assign bad_mask   = bad_mask_q;
  assign err_cnt    = err_cnt_q;
  assign irq_req    = irq_req_q;
  assign fault      = fault_q;
endmodule
